// File: rtl/bk_pkg.sv
// Shared types and helpers for the Brent-Kung block accumulator.
package bk_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/BK_Adder16Bit.sv
// 16-bit Brent-Kung parallel-prefix adder, carry-in tied to zero.
module BK_Adder16Bit
    import bk_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W:0]   sumTotal
);

    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] gg;
    logic [DATA_W-1:0] pp;

    assign p = x ^ y;
    assign g = x & y;

    // In-place prefix tree: the partner node of each level is never rewritten
    // in that same level, so sequential updates inside one block are safe.
    always_comb begin
        gg = g;
        pp = p;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
        for (int l = 2; l >= 0; l--) begin
            for (int i = 0; i < DATA_W; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i > (1 << l))) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
    end

    assign sumTotal = {gg[DATA_W-1], p[DATA_W-1:1] ^ gg[DATA_W-2:0], p[0]};

endmodule

// File: rtl/bk_block_accumulator.sv
// Block accumulator around the Brent-Kung adder: sums BLOCK_LEN samples into
// a {carry_cnt, acc} result presented on a valid/ready output.
module bk_block_accumulator
    import bk_pkg::*;
#(
    parameter int BLOCK_LEN = 8,
    parameter int CARRY_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W+CARRY_W-1:0] out_sum,
    output logic                      out_ovf,
    output logic                      busy
);

    localparam int CNT_W = clog2(BLOCK_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

    acc_state_t                  state_q, state_d;
    logic [DATA_W-1:0]           acc_q, acc_d;
    logic [CARRY_W-1:0]          carry_q, carry_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        ovf_q, ovf_d;
    logic [DATA_W+CARRY_W-1:0]   out_sum_q, out_sum_d;
    logic                        out_ovf_q, out_ovf_d;
    logic [DATA_W:0]             sum;

    BK_Adder16Bit u_adder (
        .x        (acc_q),
        .y        (in_data),
        .sumTotal (sum)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = sum[DATA_W-1:0];
                    carry_d = carry_q + CARRY_W'(sum[DATA_W]);
                    ovf_d   = ovf_q | ((&carry_q) & sum[DATA_W]);
                    if (cnt_q == LAST) begin
                        state_d   = DONE;
                        out_sum_d = {carry_d, sum[DATA_W-1:0]};
                        out_ovf_d = ovf_d;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // Result is held until consumed; start here chains the next block.
                if (out_ready) begin
                    if (start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        carry_d = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bk_block_accumulator.sv
// Directed bench: main instance, a CARRY_W=2 twin sharing its inputs, and a
// BLOCK_LEN=1 instance with its own inputs.
module tb_bk_block_accumulator;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_ovf, busy;
    logic [23:0] out_sum;
    logic        in_ready1, out_valid1, out_ovf1, busy1;
    logic [17:0] out_sum1;
    logic        start2, in_valid2, out_ready2;
    logic [15:0] in_data2;
    logic        in_ready2, out_valid2, out_ovf2, busy2;
    logic [23:0] out_sum2;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    bk_block_accumulator #(.BLOCK_LEN(8), .CARRY_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy));

    bk_block_accumulator #(.BLOCK_LEN(8), .CARRY_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready1), .in_data(in_data), .out_valid(out_valid1),
        .out_ready(out_ready), .out_sum(out_sum1), .out_ovf(out_ovf1), .busy(busy1));

    bk_block_accumulator #(.BLOCK_LEN(1), .CARRY_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
        .in_ready(in_ready2), .in_data(in_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_sum(out_sum2), .out_ovf(out_ovf2), .busy(busy2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a block from IDLE and feeds n samples of d, optionally with a
    // one-cycle in_valid gap after each sample except the last.
    task automatic run_block(input logic [15:0] d, input int n, input bit gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("in_ready_accum", in_ready, 1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = d;
            tick();
            if (i < n - 1) chk("no_early_valid", out_valid, 0);
            if (gap && i < n - 1) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        chk("out_valid_lat1", out_valid, 1);
        chk("in_ready_done", in_ready, 0);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        start2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; in_data2 = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);

        // Basic block
        run_block(16'h0001, 8, 1'b0);
        chk("basic_sum", out_sum, 32'h00_0008);
        chk("basic_ovf", out_ovf, 0);
        chk("basic_busy", busy, 1);
        consume();

        // Carry path; the CARRY_W=2 twin wraps its carry counter
        run_block(16'hFFFF, 8, 1'b0);
        chk("carry_sum", out_sum, 32'h07_FFF8);
        chk("carry_ovf", out_ovf, 0);
        chk("ovf2_valid", out_valid1, 1);
        chk("ovf2_sum", out_sum1, 32'h3_FFF8);
        chk("ovf2_ovf", out_ovf1, 1);
        consume();

        // Gapped input, then backpressure with in_valid toggling
        run_block(16'h8000, 8, 1'b1);
        chk("gap_sum", out_sum, 32'h04_0000);
        in_data = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", out_sum, 32'h04_0000);
        end
        in_valid  = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("b2b_valid", out_valid, 0);
        chk("b2b_in_ready", in_ready, 1);
        chk("b2b_sum_kept", out_sum, 32'h04_0000);

        // Reset mid-block
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_ovf", out_ovf, 0);
        run_block(16'h0002, 8, 1'b0);
        chk("after_rst_sum", out_sum, 32'h00_0010);
        consume();

        // BLOCK_LEN=1 instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("bl1_in_ready", in_ready2, 1);
        chk("bl1_idle_valid", out_valid2, 0);
        in_valid2 = 1'b1;
        in_data2  = 16'hABCD;
        tick();
        in_valid2 = 1'b0;
        chk("bl1_valid", out_valid2, 1);
        chk("bl1_sum", out_sum2, 32'h00_ABCD);
        chk("bl1_ovf", out_ovf2, 0);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        chk("bl1_drop", out_valid2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bk_block_accumulator.md
Name: bk_block_accumulator

Overview:
Sequential accumulator that sits directly around the 16-bit Brent-Kung adder. It feeds the adder one operand per accepted sample, and the adder's other operand is the running sum. It consumes the adder's 17-bit result: the low 16 bits return to the running-sum register, and the carry-out increments an upper carry counter. After BLOCK_LEN samples, it presents a wide block sum on a valid/ready output.

Parameters:
BLOCK_LEN, 8, samples per block; legal range 1..256.
CARRY_W, 8, width of the carry-out counter; out_sum width is 16+CARRY_W.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  begin a new block; sampled only in IDLE or in DONE with out_ready=1.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  block accepts in_data; high only in ACCUM.
in_data  in  16  unsigned sample.
out_valid  out  1  out_sum/out_ovf are valid.
out_ready  in  1  consumer accepts the result.
out_sum  out  16+CARRY_W  {carry_cnt, acc}; unsigned block sum modulo 2^(16+CARRY_W).
out_ovf  out  1  sticky: the carry counter wrapped during this block.
busy  out  1  high in ACCUM or DONE.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: state=IDLE, acc=0, carry_cnt=0, sample_cnt=0, in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- Reset mid-operation: the partial sum is discarded, and all registers take their reset values on the next edge.
- Adder operands: x=acc, y=in_data. The result sum[16:0] is combinational. Adder sits between the acc register and in_data; no extra pipeline stage.
- FSM: IDLE -> ACCUM -> DONE.
- IDLE:
  - in_ready=0 and out_valid=0; in_valid is ignored.
  - start=1 -> ACCUM. On that edge: acc=0, carry_cnt=0, sample_cnt=0, ovf=0.
- ACCUM:
  - in_ready=1. start is ignored.
  - On in_valid&in_ready: acc<=sum[15:0], carry_cnt<=carry_cnt+sum[16] (wraps), sample_cnt++.
  - If carry_cnt is all-ones and sum[16]=1, ovf<=1 (sticky for the block).
  - in_valid=0 cycles make no change; gaps of any length are allowed.
- Block end:
  - The handshake with sample_cnt==BLOCK_LEN-1 -> DONE.
  - On that edge: out_sum<={carry_cnt+sum[16], sum[15:0]} and out_ovf<=final ovf.
  - out_valid is high on the next cycle. Latency is 1 cycle from the last accepted sample.
- BLOCK_LEN=1: DONE follows the first accepted sample.
- DONE:
  - out_valid=1 and in_ready=0.
  - out_sum and out_ovf are held stable until out_ready=1.
  - out_ready=1 & start=0 -> IDLE; out_valid drops on the next cycle.
  - out_ready=1 & start=1 -> ACCUM directly (back-to-back blocks) with registers cleared. out_sum keeps its last value but out_valid=0.
  - start with out_ready=0 is ignored.
- Counter widths:
  - sample_cnt is $clog2(BLOCK_LEN+1) bits and never exceeds BLOCK_LEN-1.
  - carry_cnt is CARRY_W bits, modulo arithmetic.
- Invariant: no input handshake while out_valid=1, so results are never overwritten before being consumed.

Decomposition:
- Package bk_pkg:
  - constant DATA_W=16.
  - typedef enum of acc_state_t {IDLE, ACCUM, DONE}.
  - function clog2 helper for the counter width.
- One sub-module instance: BK_Adder16Bit (x=acc, y=in_data, sumTotal=sum[16:0]), unmodified.
- The FSM, counters and output register live in bk_block_accumulator.

Test Plan:
- Basic block: reset, start, 8 samples of 0x0001 back-to-back -> out_valid 1 cycle after the 8th accept; out_sum=0x00_0008, out_ovf=0.
- Carry path: 8 samples of 0xFFFF -> out_sum=0x07_FFF8 (carry_cnt=7, acc=0xFFF8), out_ovf=0.
- Overflow: CARRY_W=2 instance, 8 samples of 0xFFFF -> out_sum={2'b11,0xFFF8}, out_ovf=1.
- Gapped input and backpressure:
  - Stimulus: in_valid alternating 1/0 with 8 samples of 0x8000, then out_ready low 5 cycles with in_valid toggling.
  - Required response: out_sum=0x04_0000 stable throughout, and in_ready=0 while out_valid=1.
  - Then start=1 and out_ready=1 in the same cycle -> ACCUM next cycle, out_valid=0.
- Reset mid-block: 3 samples of 0x1234, then rst_n=0 for one edge -> all outputs at reset values. Then start with 8 samples of 0x0002 -> out_sum=0x00_0010.
- BLOCK_LEN=1 instance: start, one sample 0xABCD -> out_valid on the next cycle, out_sum=0x00_ABCD.
